// File: rtl/cozy_mem_arbiter.sv
// Shares one synchronous-read RAM port between the cozy CPU and the video fetcher.
// Video wins up to VID_BURST consecutive slots. The stalled CPU is frozen via cpu_ce and sees its last read data held.
module cozy_mem_arbiter #(
  parameter int unsigned VID_BURST = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [1:0]  cpu_bwe,
  input  logic [15:0] cpu_dout,
  output logic [15:0] cpu_din,
  output logic        cpu_ce,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic        vid_ack,
  output logic        vid_valid,
  output logic [15:0] vid_data,
  output logic [15:0] ram_addr,
  output logic [1:0]  ram_bwe,
  output logic [15:0] ram_dout,
  input  logic [15:0] ram_din
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_VID  = 2'b10
  } owner_t;

  localparam logic [3:0] BURST_CAP = 4'(VID_BURST);

  owner_t      last_owner;
  owner_t      next_owner;
  logic [3:0]  burst_cnt;
  logic [3:0]  burst_next;
  logic [15:0] cpu_hold;
  logic        gnt_vid;
  logic        gnt_cpu;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_owner <= OWN_NONE;
      burst_cnt  <= '0;
      cpu_hold   <= '0;
    end else begin
      last_owner <= next_owner;
      burst_cnt  <= burst_next;
      if (last_owner == OWN_CPU) begin
        cpu_hold <= ram_din;
      end
    end
  end

  // Grants depend on reset_n directly so neither side owns the RAM while reset is held.
  always_comb begin
    gnt_vid    = reset_n & vid_req & (burst_cnt < BURST_CAP);
    gnt_cpu    = reset_n & ~gnt_vid;
    next_owner = OWN_NONE;
    burst_next = '0;
    if (gnt_vid) begin
      next_owner = OWN_VID;
      burst_next = burst_cnt + 4'd1;
    end else if (gnt_cpu) begin
      next_owner = OWN_CPU;
    end
  end

  always_comb begin
    vid_ack   = gnt_vid;
    cpu_ce    = gnt_cpu;
    ram_addr  = gnt_cpu ? cpu_addr : vid_addr;
    ram_bwe   = gnt_cpu ? cpu_bwe : '0;
    ram_dout  = cpu_dout;
    vid_valid = (last_owner == OWN_VID);
    vid_data  = ram_din;
    cpu_din   = (last_owner == OWN_CPU) ? ram_din : cpu_hold;
  end

endmodule

// File: doc/cozy_mem_arbiter.md
Name: cozy_mem_arbiter

Overview:
- Shares the single synchronous-read RAM port between the cozy CPU and the terminal video fetcher.
- Video reads take priority, limited by a burst cap. The CPU is frozen through a clock-enable whenever it loses the slot.
- Read data is steered back to the requester that owned the slot one cycle earlier.
- For a stalled CPU, the arbiter holds the read data it last returned, so the CPU's combinational datapath sees stable input.

Parameters:
- VID_BURST, 4: max consecutive video grants before one forced CPU slot. Legal range 1..15.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpu_addr  in  16  CPU byte address, combinational from CPU
- cpu_bwe  in  2  CPU byte write enables, [1]=high byte, [0]=low byte
- cpu_dout  in  16  CPU write data
- cpu_din  out  16  read data to CPU
- cpu_ce  out  1  CPU clock enable; CPU state advances only on edges where this is 1
- vid_req  in  1  video fetcher requests a read this cycle
- vid_addr  in  16  video read address, held stable while vid_req=1 and vid_ack=0
- vid_ack  out  1  video owns the RAM this cycle; address accepted at this edge
- vid_valid  out  1  vid_data holds the result of the previous cycle's vid_ack
- vid_data  out  16  video read data
- ram_addr  out  16  RAM address
- ram_bwe  out  2  RAM byte write enables
- ram_dout  out  16  RAM write data
- ram_din  in  16  RAM read data, valid one cycle after ram_addr is sampled

Behaviour:
- Registered state:
  - last_owner: 2 bits, values NONE, CPU or VID
  - burst_cnt: 4 bits
  - cpu_hold: 16 bits
- All state is cleared asynchronously when reset_n=0: last_owner=NONE, burst_cnt=0, cpu_hold=0.
- Grant, combinational:
  - gnt_vid = reset_n & vid_req & (burst_cnt < VID_BURST)
  - gnt_cpu = reset_n & ~gnt_vid
- Outputs while owned:
  - vid_ack = gnt_vid; cpu_ce = gnt_cpu.
  - Under reset, vid_ack=0 and cpu_ce=0.
- RAM mux when gnt_cpu:
  - ram_addr=cpu_addr, ram_bwe=cpu_bwe, ram_dout=cpu_dout.
- RAM mux otherwise:
  - ram_addr=vid_addr, ram_bwe=00, ram_dout=cpu_dout. Video never writes.
- burst_cnt at each edge:
  - gnt_vid: burst_cnt+1.
  - gnt_cpu: 0.
- last_owner at each edge:
  - CPU if gnt_cpu, VID if gnt_vid, NONE under reset.
- Return path, combinational on last_owner:
  - CPU: cpu_din=ram_din; cpu_hold captures ram_din at the edge.
  - VID or NONE: cpu_din=cpu_hold.
  - vid_valid = (last_owner==VID); vid_data=ram_din.
  - vid_data is don't-care when vid_valid=0, but is driven to ram_din anyway.
- Latency:
  - A video request with no cap pressure gets vid_ack in the same cycle and vid_valid the next cycle. Read latency is 1.
  - Back-to-back video requests pipeline at 1 word/cycle until the cap is hit.
- Cap:
  - After VID_BURST consecutive vid_acks, the next cycle is forced to the CPU (cpu_ce=1, vid_ack=0) even with vid_req=1.
  - burst_cnt then clears and video may win again on the following cycle.
  - The CPU is therefore guaranteed at least 1 slot in every VID_BURST+1 cycles.
- CPU writes happen only on CPU-owned cycles. A stalled CPU's bwe never reaches RAM.
- A stalled CPU presents an unchanged cpu_addr/cpu_bwe. The arbiter relies on this and does not latch them.
- The first cycle after reset release is CPU-owned unless vid_req=1. cpu_din=0 until the first CPU-owned read returns.
- Reset mid-operation:
  - Any in-flight video read is dropped (vid_valid=0); the fetcher must reissue.
  - cpu_hold is cleared.
- vid_req dropping in a cycle gives that slot to the CPU. The burst count clears.

Test Plan:
- Idle video (vid_req=0), CPU reading 0x0000, 0x0002 and 0x0004 on successive cycles:
  - cpu_ce=1 every cycle.
  - ram_addr tracks cpu_addr.
  - cpu_din returns RAM[0x0000], RAM[0x0002] and RAM[0x0004], each one cycle later.
- vid_req held high with VID_BURST=4, vid_addr stepping 0x8000, 0x8002, …:
  - Grant pattern is V,V,V,V,C repeating; cpu_ce=1 only every 5th cycle.
  - vid_valid follows each vid_ack by 1 cycle with matching data.
- CPU read of 0x1234 granted, then video wins 3 cycles:
  - cpu_din = RAM[0x1234] on the cycle after the grant.
  - It stays equal to RAM[0x1234] for all 3 stalled cycles, unaffected by video data on ram_din.
- CPU store word (cpu_bwe=11, addr 0x0100, data 0xBEEF) while video is requesting:
  - ram_bwe=00 on video cycles.
  - RAM[0x0100]=0xBEEF written only on the CPU-owned cycle, exactly once.
- Assert reset_n=0 for one cycle, asynchronously mid-cycle, immediately after a vid_ack:
  - vid_valid=0 immediately, cpu_din=0 and burst_cnt=0.
  - After release with vid_req=0, cpu_ce=1.
- vid_req pulses 1,0,1 with VID_BURST=1:
  - Grants are V,C,V; burst_cnt resets on the CPU slot.
  - vid_valid is 0,1,0,1 with the one-cycle offset.
